// File: rtl/vga_pkg.sv
// Shared definitions for the 800x600 VGA draw pipeline: geometry, widths,
// colours and the timing-bus bundle passed between draw stages.
package vga_pkg;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int RGB_W    = 12;
  localparam int CNT_W    = 11;

  localparam logic [RGB_W-1:0] RGB_BLACK   = 12'h0_0_0;
  localparam logic [RGB_W-1:0] RGB_GREY    = 12'h8_8_8;
  localparam logic [RGB_W-1:0] RGB_MAGENTA = 12'hf_0_f;

  typedef enum logic {
    POS_IDLE    = 1'b0,
    POS_PENDING = 1'b1
  } pos_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             hblnk;
    logic             vsync;
    logic             vblnk;
  } vga_timing_t;
endpackage

// File: rtl/pos_sync.sv
// Position handshake: holds a requested position until the next vblank rising
// edge, then makes it active and pulses pos_ack_o for one cycle.
module pos_sync import vga_pkg::*; #(
  parameter int XPOS_INIT = 0,
  parameter int YPOS_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vblnk_i,
  input  logic             pos_valid_i,
  input  logic [CNT_W-1:0] xpos_i,
  input  logic [CNT_W-1:0] ypos_i,
  output logic [CNT_W-1:0] xpos_act_o,
  output logic [CNT_W-1:0] ypos_act_o,
  output logic             pos_ack_o
);
  pos_state_e       state_q;
  logic             vblnk_prev_q;
  logic             ack_q;
  logic [CNT_W-1:0] xpend_q, ypend_q;
  logic [CNT_W-1:0] xact_q, yact_q;
  logic             vblnk_rise;

  assign vblnk_rise = vblnk_i && !vblnk_prev_q;
  assign xpos_act_o = xact_q;
  assign ypos_act_o = yact_q;
  assign pos_ack_o  = ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= POS_IDLE;
      vblnk_prev_q <= 1'b0;
      ack_q        <= 1'b0;
      xpend_q      <= '0;
      ypend_q      <= '0;
      xact_q       <= XPOS_INIT[CNT_W-1:0];
      yact_q       <= YPOS_INIT[CNT_W-1:0];
    end else begin
      vblnk_prev_q <= vblnk_i;
      ack_q        <= 1'b0;
      case (state_q)
        POS_IDLE: begin
          if (pos_valid_i && vblnk_rise) begin
            // request lands exactly on the edge: bypass the pending registers
            xact_q <= xpos_i;
            yact_q <= ypos_i;
            ack_q  <= 1'b1;
          end else if (pos_valid_i) begin
            xpend_q <= xpos_i;
            ypend_q <= ypos_i;
            state_q <= POS_PENDING;
          end
        end
        POS_PENDING: begin
          if (vblnk_rise) begin
            xact_q  <= pos_valid_i ? xpos_i : xpend_q;
            yact_q  <= pos_valid_i ? ypos_i : ypend_q;
            ack_q   <= 1'b1;
            state_q <= POS_IDLE;
          end else if (pos_valid_i) begin
            xpend_q <= xpos_i;
            ypend_q <= ypos_i;
          end
        end
        default: state_q <= POS_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/draw_rect.sv
// Two-stage overlay: paints a solid WIDTH x HEIGHT rectangle over the
// background at a position that only moves at vblank.
module draw_rect import vga_pkg::*; #(
  parameter int               WIDTH     = 48,
  parameter int               HEIGHT    = 64,
  parameter logic [RGB_W-1:0] RECT_RGB  = 12'hf_0_f,
  parameter int               XPOS_INIT = 0,
  parameter int               YPOS_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] hcount_in,
  input  logic [CNT_W-1:0] vcount_in,
  input  logic             hsync_in,
  input  logic             hblnk_in,
  input  logic             vsync_in,
  input  logic             vblnk_in,
  input  logic [RGB_W-1:0] rgb_in,
  input  logic [CNT_W-1:0] xpos_in,
  input  logic [CNT_W-1:0] ypos_in,
  input  logic             pos_valid,
  output logic             pos_ack,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic [RGB_W-1:0] rgb_out
);
  localparam logic [CNT_W:0] W_EXT = (CNT_W+1)'(WIDTH);
  localparam logic [CNT_W:0] H_EXT = (CNT_W+1)'(HEIGHT);

  logic [CNT_W-1:0] xpos_act, ypos_act;
  logic [CNT_W:0]   x_end, y_end;
  logic             in_x_d, in_y_d, in_x_q, in_y_q;
  vga_timing_t      tim_d, tim1_q, tim2_q;
  logic [RGB_W-1:0] rgb1_q, rgb_d, rgb2_q;

  pos_sync #(
    .XPOS_INIT (XPOS_INIT),
    .YPOS_INIT (YPOS_INIT)
  ) u_pos_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .vblnk_i     (vblnk_in),
    .pos_valid_i (pos_valid),
    .xpos_i      (xpos_in),
    .ypos_i      (ypos_in),
    .xpos_act_o  (xpos_act),
    .ypos_act_o  (ypos_act),
    .pos_ack_o   (pos_ack)
  );

  // one extra bit so a rectangle near the right/bottom edge never wraps to 0
  assign x_end  = {1'b0, xpos_act} + W_EXT;
  assign y_end  = {1'b0, ypos_act} + H_EXT;
  assign in_x_d = (hcount_in >= xpos_act) && ({1'b0, hcount_in} < x_end);
  assign in_y_d = (vcount_in >= ypos_act) && ({1'b0, vcount_in} < y_end);

  assign tim_d = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                   hblnk: hblnk_in, vsync: vsync_in, vblnk: vblnk_in};

  always_comb begin
    rgb_d = rgb1_q;
    if (tim1_q.hblnk || tim1_q.vblnk) rgb_d = RGB_BLACK;
    else if (in_x_q && in_y_q)        rgb_d = RECT_RGB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tim1_q <= '0;
      rgb1_q <= '0;
      in_x_q <= 1'b0;
      in_y_q <= 1'b0;
      tim2_q <= '0;
      rgb2_q <= '0;
    end else begin
      tim1_q <= tim_d;
      rgb1_q <= rgb_in;
      in_x_q <= in_x_d;
      in_y_q <= in_y_d;
      tim2_q <= tim1_q;
      rgb2_q <= rgb_d;
    end
  end

  assign hcount_out = tim2_q.hcount;
  assign vcount_out = tim2_q.vcount;
  assign hsync_out  = tim2_q.hsync;
  assign hblnk_out  = tim2_q.hblnk;
  assign vsync_out  = tim2_q.vsync;
  assign vblnk_out  = tim2_q.vblnk;
  assign rgb_out    = rgb2_q;
endmodule

// File: tb/tb_draw_rect.sv
// Scoreboard bench for draw_rect: sparse frames of selected pixels, expected
// outputs queued at stimulus time and checked by an independent monitor.
module tb_draw_rect;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0, xpos_in = '0, ypos_in = '0;
  logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic        pos_valid = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        pos_ack;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_rect #(.WIDTH(48), .HEIGHT(64), .RECT_RGB(12'hf0f),
              .XPOS_INIT(100), .YPOS_INIT(200)) dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos_in(xpos_in), .ypos_in(ypos_in), .pos_valid(pos_valid),
    .pos_ack(pos_ack),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] h, v;
    logic        hs, hb, vs, vb;
    logic [11:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  bit   ack_q[$];
  int   checks = 0, failures = 0, ack_cnt = 0;
  bit   mon_en = 0, issued = 0, prev_a1 = 0;

  // reference position model
  int m_ax = 100, m_ay = 200, m_px = 0, m_py = 0;
  bit m_pend = 0, m_vprev = 0;

  int rows[23] = '{0, 9, 10, 11, 19, 20, 49, 50, 83, 84, 113, 114, 199, 200,
                   263, 264, 399, 400, 463, 464, 579, 580, 599};
  int cols[18] = '{0, 19, 20, 67, 99, 100, 147, 148, 300, 347, 348, 399, 400,
                   447, 448, 779, 780, 799};

  task automatic drive(input int h, input int v, input bit hs, input bit hb,
                       input bit vs, input bit vb, input bit pv,
                       input int xp, input int yp);
    exp_t e;
    bit   apply;
    @(negedge clk); #1;
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = hs; hblnk_in = hb; vsync_in = vs; vblnk_in = vb;
    rgb_in = 12'h888; pos_valid = pv; xpos_in = 11'(xp); ypos_in = 11'(yp);
    e.h = 11'(h); e.v = 11'(v); e.hs = hs; e.hb = hb; e.vs = vs; e.vb = vb;
    if (hb || vb) e.rgb = 12'h000;
    else if (h >= m_ax && h < m_ax + 48 && v >= m_ay && v < m_ay + 64) e.rgb = 12'hf0f;
    else e.rgb = 12'h888;
    exp_q.push_back(e);
    apply = vb && !m_vprev && (m_pend || pv);
    ack_q.push_back(apply);
    if (apply) begin
      m_ax = pv ? xp : m_px; m_ay = pv ? yp : m_py; m_pend = 0;
    end else if (pv) begin
      m_px = xp; m_py = yp; m_pend = 1;
    end
    m_vprev = vb;
    issued = 1;
  endtask

  // s1/s2: strobes at column 0 of the given row (-1 = none); vbs: strobe on
  // the first vblank cycle
  task automatic frame(input int s1r, input int s1x, input int s1y,
                       input int s2r, input int s2x, input int s2y,
                       input bit vbs, input int vbx, input int vby);
    for (int r = 0; r < 23; r++) begin
      for (int c = 0; c < 18; c++) begin
        bit pv1, pv2;
        pv1 = (rows[r] == s1r) && (c == 0);
        pv2 = (rows[r] == s2r) && (c == 0);
        drive(cols[c], rows[r], 0, 0, 0, 0, pv1 || pv2,
              pv2 ? s2x : s1x, pv2 ? s2y : s1y);
      end
      drive(800, rows[r], 0, 1, 0, 0, 0, 0, 0);
      drive(840, rows[r], 1, 1, 0, 0, 0, 0, 0);
    end
    for (int k = 0; k < 6; k++)
      drive((k == 5) ? 790 : 100 * k, 600 + k, 0, 0, k >= 3, 1,
            vbs && (k == 0), vbx, vby);
  endtask

  task automatic chk_acks(input int exp_n, input string nm);
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (ack_cnt != exp_n) begin
      failures++;
      $display("FAIL %s: pos_ack pulses=%0d expected=%0d", nm, ack_cnt, exp_n);
    end
    ack_cnt = 0;
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if ({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out,
         rgb_out, pos_ack} !== '0) begin
      failures++;
      $display("FAIL %s: outputs h=%0d v=%0d sync/blnk=%b%b%b%b rgb=%h ack=%b, expected all 0",
               nm, hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out,
               rgb_out, pos_ack);
    end
  endtask

  // monitor: ack is due one cycle after issue, pixel/timing two cycles after
  initial begin
    exp_t e;
    bit   a;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_a1) begin
          checks += 2;
          if (exp_q.size() == 0) begin
            failures += 2;
            $display("FAIL scoreboard: pixel expectation queue empty");
          end else begin
            e = exp_q.pop_front();
            if ({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} !==
                {e.h, e.v, e.hs, e.hb, e.vs, e.vb}) begin
              failures++;
              $display("FAIL timing @(%0d,%0d): got h=%0d v=%0d hs/hb/vs/vb=%b%b%b%b expected %b%b%b%b",
                       e.h, e.v, hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out,
                       vblnk_out, e.hs, e.hb, e.vs, e.vb);
            end
            if (rgb_out !== e.rgb) begin
              failures++;
              $display("FAIL rgb @(%0d,%0d): got %h expected %h", e.h, e.v, rgb_out, e.rgb);
            end
          end
        end
        if (issued) begin
          checks++;
          if (ack_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard: ack expectation queue empty");
          end else begin
            a = ack_q.pop_front();
            if (pos_ack !== a) begin
              failures++;
              $display("FAIL pos_ack @(%0d,%0d): got %b expected %b",
                       hcount_in, vcount_in, pos_ack, a);
            end
          end
        end
        if (pos_ack === 1'b1) ack_cnt++;
        prev_a1 = issued;
        issued  = 0;
      end
    end
  end

  initial begin
    #3;
    chk_zero("reset_state");
    @(negedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1;

    frame(-1, 0, 0, -1, 0, 0, 0, 0, 0);           // init position (100,200)
    chk_acks(0, "no_request_frame");
    frame(10, 300, 50, -1, 0, 0, 0, 0, 0);        // still (100,200) this frame
    chk_acks(1, "single_request");
    frame(-1, 0, 0, -1, 0, 0, 0, 0, 0);           // now (300,50)
    chk_acks(0, "after_apply");
    frame(10, 10, 10, 50, 20, 20, 0, 0, 0);       // latest wins
    chk_acks(1, "double_request");
    frame(-1, 0, 0, -1, 0, 0, 1, 400, 400);       // bypass on vblank edge
    chk_acks(1, "bypass_request");
    frame(-1, 0, 0, -1, 0, 0, 0, 0, 0);           // (400,400), nothing pending
    chk_acks(0, "after_bypass");
    frame(0, 780, 580, -1, 0, 0, 0, 0, 0);
    chk_acks(1, "edge_request");
    frame(-1, 0, 0, -1, 0, 0, 0, 0, 0);           // clipped at 799/599
    chk_acks(0, "clipped_frame");

    // reset mid-frame with a request pending
    for (int c = 0; c < 18; c++)
      drive(cols[c], 10, 0, 0, 0, 0, c == 0, 300, 50);
    @(negedge clk); #2;
    rst_n  = 1'b0;
    mon_en = 0;
    #1;
    chk_zero("async_reset");
    repeat (3) @(negedge clk);
    #1;
    chk_zero("held_reset");
    exp_q.delete(); ack_q.delete();
    prev_a1 = 0; issued = 0; ack_cnt = 0;
    m_ax = 100; m_ay = 200; m_pend = 0; m_vprev = 0;
    rst_n  = 1'b1;
    mon_en = 1;
    frame(-1, 0, 0, -1, 0, 0, 0, 0, 0);           // back at (100,200), no ack
    chk_acks(0, "after_reset");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/draw_rect.md
Name: draw_rect

Overview:
- Overlay stage placed directly downstream of draw_background in the 800x600 VGA pipeline.
- Consumes the timing bus (hcount, vcount, sync and blank signals) plus the background rgb.
- Paints a solid WIDTH x HEIGHT rectangle at a run-time position over the background.
- New positions are accepted through a valid/ack handshake and take effect only at the start of vertical blank, so a frame never tears.

Parameters:
- WIDTH, 48, rectangle width in pixels (1..800)
- HEIGHT, 64, rectangle height in pixels (1..600)
- RECT_RGB, 12'hf_0_f, rectangle colour
- XPOS_INIT, 0, active x position after reset
- YPOS_INIT, 0, active y position after reset

Ports:
- clk  in  1  pixel clock (40 MHz domain), all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- hcount_in  in  11  horizontal count from draw_background
- vcount_in  in  11  vertical count from draw_background
- hsync_in  in  1  horizontal sync
- hblnk_in  in  1  horizontal blank
- vsync_in  in  1  vertical sync
- vblnk_in  in  1  vertical blank
- rgb_in  in  12  background colour
- xpos_in  in  11  requested rectangle left edge
- ypos_in  in  11  requested rectangle top edge
- pos_valid  in  1  one-cycle strobe: xpos_in/ypos_in valid
- pos_ack  out  1  one-cycle pulse when a requested position becomes active
- hcount_out  out  11  hcount_in delayed 2 cycles
- vcount_out  out  11  vcount_in delayed 2 cycles
- hsync_out  out  1  delayed 2 cycles
- hblnk_out  out  1  delayed 2 cycles
- vsync_out  out  1  delayed 2 cycles
- vblnk_out  out  1  delayed 2 cycles
- rgb_out  out  12  composited colour, aligned with the delayed timing

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs and pipeline registers clear to 0.
  - Active position = (XPOS_INIT, YPOS_INIT).
  - Pending flag = 0; vblnk_prev = 0.
- Latency: fixed 2 cycles from any input to the matching outputs; all timing outputs and rgb_out stay mutually aligned.
- Stage 1 (registered):
  - Delay the timing bus and rgb_in.
  - in_x = hcount_in >= xpos_act && hcount_in < xpos_act + WIDTH.
  - in_y = vcount_in >= ypos_act && vcount_in < ypos_act + HEIGHT.
  - Compute the sums at 12 bits so xpos_act + WIDTH cannot wrap.
- Stage 2 (registered):
  - rgb_out = 0 if hblnk or vblnk is set.
  - Otherwise rgb_out = RECT_RGB if in_x && in_y.
  - Otherwise rgb_out = delayed rgb_in.
- Clipping: a rectangle extending past column 799 or row 599 is cut off by the blank signals. There is no wrap to column or row 0.
- Position handshake:
  - pos_valid = 1 captures xpos_in/ypos_in into the pending registers and sets pending = 1. A later strobe before apply overwrites pending (latest wins).
  - Apply event: vblnk_in rising edge (vblnk_in && !vblnk_prev) with pending = 1.
  - On apply: active <= pending, pending <= 0, pos_ack = 1 on the next cycle for exactly one cycle.
  - pos_valid in the same cycle as an apply event: the incoming xpos_in/ypos_in are applied directly (bypass), pending clears, and one pos_ack is issued.
  - Apply event with pending = 0: no change, no ack.
- State machine (position control): IDLE (pending = 0) and PENDING (pending = 1).
  - IDLE -> PENDING on pos_valid without apply.
  - PENDING -> IDLE on apply.
  - IDLE + pos_valid + apply -> IDLE with ack.
- Reset mid-frame: the pending request is discarded and no ack is issued. Drawing resumes at XPOS_INIT/YPOS_INIT on the next valid pixel after deassertion.
- Active position never changes while vblnk_in = 0.

Decomposition:
- Shared package vga_pkg:
  - H_ACTIVE = 800, V_ACTIVE = 600
  - RGB_W = 12, CNT_W = 11
  - Colour constants used across draw stages
- Sub-module pos_sync: the handshake FSM, pending/active registers, vblank edge detect and pos_ack. It is reused by later sprite and cursor stages.
- Top draw_rect contains the 2-stage compositing pipeline.

Test Plan:
- Reset with XPOS_INIT = 100, YPOS_INIT = 200, drive a full frame with rgb_in = 12'h888:
  - pixels (100..147, 200..263) = 12'hf0f, pixel (99, 200) = 12'h888, pixel (148, 263) = 12'h888.
  - Every timing output equals its input 2 cycles earlier.
- Strobe pos_valid with (300, 50) mid-frame at vcount = 10:
  - rest of the frame still draws at (100, 200).
  - pos_ack pulses once, 1 cycle after vblnk rises.
  - next frame draws at (300..347, 50..113).
- Two strobes before vblank, (10, 10) then (20, 20):
  - only (20, 20) is applied; exactly one pos_ack.
- pos_valid = (400, 400) in the same cycle as the vblnk rising edge:
  - immediate apply, a single ack, pending stays 0 afterwards.
- Position (780, 580):
  - rectangle covers columns 780..799 and rows 580..599 only.
  - rgb_out = 0 throughout blanking; no pixels drawn at column 0 or row 0.
- Assert rst_n low mid-frame while pending:
  - all outputs go 0 asynchronously, no ack.
  - after release the rectangle is drawn at XPOS_INIT/YPOS_INIT.
